bcd_timekeeper: RTL

Parametrised time-of-day core: a prescaled BCD HH:MM:SS counter with run-time 12/24-hour display mode, a validated load handshake, a latched HH:MM alarm and an integrated 7-segment encoder. It replaces the fixed counter/display pair. It sits between board clock/switch inputs and the six-digit 7-segment bank.

---
 rtl/bcd_timekeeper.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/bcd_timekeeper.sv
// Time-of-day core: prescaled BCD HH:MM:SS counter with a validated load handshake,
// 12/24-hour display, HH:MM alarm and 7-segment encoding of the six displayed digits.
module bcd_timekeeper #(
  parameter int CLK_DIV        = 50_000_000,
  parameter int CNT_W          = $clog2(CLK_DIV),
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic             mode_12h,
  input  logic             load_valid,
  input  logic [3:0]       load_time [6],
  output logic             load_ready,
  output logic             load_err,
  input  logic             alarm_en,
  input  logic [3:0]       alarm_time [4],
  output logic [3:0]       num [6],
  output logic [6:0]       seg [6],
  output logic             pm,
  output logic             sec_tick,
  output logic             day_wrap,
  output logic             alarm
);

  typedef enum logic [1:0] {RUN, CHECK, COMMIT} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] presc_q;
  logic [3:0]       tm_q [6];
  logic [3:0]       shadow_q [6];
  logic [3:0]       num_q [6];
  logic             pm_q, sec_tick_q, day_wrap_q, alarm_q, load_err_q, load_ready_q;

  logic [3:0]       tm_d [6];
  logic [3:0]       num_d [6];
  logic             tick, wrap_d, load_ok, alarm_hit, pm_d;
  logic [4:0]       hr_bin, hr12;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return SEG_ACTIVE_LOW ? p : ~p;
  endfunction

  always_comb begin
    tick      = !pause && (presc_q == CNT_W'(CLK_DIV - 1));
    tm_d      = tm_q;
    wrap_d    = 1'b0;
    // BCD carry chain, seconds units upward; hours roll 23 -> 00
    if (tm_q[5] != 4'd9) tm_d[5] = tm_q[5] + 4'd1;
    else begin
      tm_d[5] = 4'd0;
      if (tm_q[4] != 4'd5) tm_d[4] = tm_q[4] + 4'd1;
      else begin
        tm_d[4] = 4'd0;
        if (tm_q[3] != 4'd9) tm_d[3] = tm_q[3] + 4'd1;
        else begin
          tm_d[3] = 4'd0;
          if (tm_q[2] != 4'd5) tm_d[2] = tm_q[2] + 4'd1;
          else begin
            tm_d[2] = 4'd0;
            if (tm_q[0] == 4'd2 && tm_q[1] == 4'd3) begin
              tm_d[0] = 4'd0;
              tm_d[1] = 4'd0;
              wrap_d  = 1'b1;
            end else if (tm_q[1] == 4'd9) begin
              tm_d[0] = tm_q[0] + 4'd1;
              tm_d[1] = 4'd0;
            end else begin
              tm_d[1] = tm_q[1] + 4'd1;
            end
          end
        end
      end
    end

    load_ok = (shadow_q[0] <= 4'd2) && (shadow_q[1] <= 4'd9) &&
              !(shadow_q[0] == 4'd2 && shadow_q[1] > 4'd3) &&
              (shadow_q[2] <= 4'd5) && (shadow_q[3] <= 4'd9) &&
              (shadow_q[4] <= 4'd5) && (shadow_q[5] <= 4'd9);

    alarm_hit = (tm_d[0] == alarm_time[0]) && (tm_d[1] == alarm_time[1]) &&
                (tm_d[2] == alarm_time[2]) && (tm_d[3] == alarm_time[3]) &&
                (tm_d[4] == 4'd0) && (tm_d[5] == 4'd0);

    hr_bin = 5'(tm_q[0]) * 5'd10 + 5'(tm_q[1]);
    hr12   = hr_bin;
    num_d  = tm_q;
    pm_d   = 1'b0;
    if (mode_12h) begin
      if (hr_bin == 5'd0)      hr12 = 5'd12;
      else if (hr_bin > 5'd12) hr12 = hr_bin - 5'd12;
      pm_d = (hr_bin >= 5'd12);
      if (hr12 >= 5'd10) begin
        num_d[0] = 4'd1;
        num_d[1] = 4'(hr12 - 5'd10);
      end else begin
        num_d[0] = 4'hF;
        num_d[1] = hr12[3:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 6; i++) seg[i] = seg_enc(num_q[i]);
  end

  // Shadow only captures on an accepted request; it needs no reset value.
  always_ff @(posedge clk) begin
    if (load_valid && load_ready_q && state_q == RUN) shadow_q <= load_time;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUN;
      presc_q      <= '0;
      tm_q         <= '{default: 4'd0};
      num_q        <= '{default: 4'd0};
      pm_q         <= 1'b0;
      sec_tick_q   <= 1'b0;
      day_wrap_q   <= 1'b0;
      alarm_q      <= 1'b0;
      load_err_q   <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
      // A tick landing on the commit edge is dropped in favour of the loaded time.
      if (state_q == COMMIT) begin
        tm_q    <= shadow_q;
        presc_q <= '0;
      end else begin
        if (!pause) presc_q <= tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          tm_q       <= tm_d;
          sec_tick_q <= 1'b1;
          day_wrap_q <= wrap_d;
        end
      end

      if (!alarm_en) alarm_q <= 1'b0;
      else if (tick && state_q != COMMIT && alarm_hit) alarm_q <= 1'b1;

      num_q <= num_d;
      pm_q  <= pm_d;

      case (state_q)
        RUN: begin
          if (load_valid) begin
            state_q      <= CHECK;
            load_ready_q <= 1'b0;
          end
        end
        CHECK: begin
          if (load_ok) state_q <= COMMIT;
          else begin
            load_err_q   <= 1'b1;
            state_q      <= RUN;
            load_ready_q <= 1'b1;
          end
        end
        COMMIT: begin
          load_err_q   <= 1'b0;
          state_q      <= RUN;
          load_ready_q <= 1'b1;
        end
        default: begin
          state_q      <= RUN;
          load_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign num        = num_q;
  assign pm         = pm_q;
  assign sec_tick   = sec_tick_q;
  assign day_wrap   = day_wrap_q;
  assign alarm      = alarm_q;
  assign load_err   = load_err_q;
  assign load_ready = load_ready_q;

endmodule
